spi_mstr_fd: RTL
================

Name: spi_mstr_fd

Overview:
Parametrised full-duplex SPI master: the next generation of the team's single-word command master. It shifts a DATA_W-bit word out on MOSI and captures DATA_W bits from MISO in the same frame. Data width, SCLK divide ratio and SPI mode (CPOL/CPHA) are all generic. It sits between the capture/control logic and external SPI peripherals (AFE gain DACs, trigger DACs, serial ADC config), one instance per chip-select.

Parameters:
DATA_W, 16, frame length in bits (legal 2..32)
DIV_LOG2, 5, SCLK period = 2^DIV_LOG2 clk cycles; half period H = 2^(DIV_LOG2-1) (legal >= 2)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge / drive on trailing edge; 1 = drive on leading edge / sample on trailing edge

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wrt  in  1  start-frame strobe, honoured only when busy=0
wdata  in  DATA_W  word to transmit, MSB first, latched in the wrt cycle
MISO  in  1  serial data from slave
SS_n  out  1  active-low slave select, registered
SCLK  out  1  serial clock, registered, glitch-free
MOSI  out  1  serial data to slave
busy  out  1  high from the cycle after an accepted wrt until done
done  out  1  one-clk pulse at frame end
rdata  out  DATA_W  captured MISO word, valid from the done pulse until the next done

Behaviour:
- Reset (async, any time including mid-frame): state=IDLE, SS_n=1, SCLK=CPOL, MOSI=0, busy=0, done=0, rdata=0, all counters cleared. The frame is abandoned and no done pulse is issued.
- States: IDLE, SETUP, XFER, HOLD.
- IDLE -> SETUP on wrt. In the wrt cycle, latch wdata into tx_sh, clear div_cnt and edge_cnt. Next cycle: SS_n=0, busy=1, MOSI=tx_sh MSB.
- SETUP lasts H cycles with SCLK=CPOL, then -> XFER.
- XFER lasts 2*DATA_W half-periods of H cycles each. SCLK toggles at each half-period boundary, starting with a leading edge, so there are DATA_W leading and DATA_W trailing edges. Then -> HOLD.
- HOLD lasts H cycles with SCLK=CPOL, then -> IDLE. In that transition cycle: SS_n=1, busy=0, done=1 for one cycle, and rdata <= final rx_sh.
- Edge actions, edges numbered k=1..DATA_W:
  - CPHA=0: sample MISO (rx_sh <= {rx_sh[DATA_W-2:0],MISO}) on leading edge k; shift tx_sh left on trailing edge k.
  - CPHA=1: shift tx_sh on leading edge k for k>=2 only, because the MSB is already presented from SS_n fall; sample on trailing edge k.
- Sampling uses the MISO value present in the clk cycle in which SCLK toggles; no extra synchroniser.
- MOSI=tx_sh[DATA_W-1] while SS_n=0, and 0 while SS_n=1.
- Latency: wrt accepted at cycle T -> SS_n falls at T+1 -> done at T+1+H*(2*DATA_W+2). Defaults: H=16, so done at T+545.
- wrt while busy=1: ignored, with no effect on the frame in progress.
- wrt in the same cycle as done: accepted, and the next frame starts (back-to-back). SS_n then stays high for exactly one cycle.
- Width rules: div_cnt is DIV_LOG2-1 bits and wraps naturally at H. edge_cnt is clog2(2*DATA_W+1) bits. No arithmetic on data.

Decomposition:
- Package spi_pkg holds the spi_state_t enum {IDLE,SETUP,XFER,HOLD} and a function for the edge-counter width.
- One sub-module, spi_sclk_gen: divider, SCLK register and lead_edge/trail_edge strobes, enabled by the FSM.
- The top level holds the FSM, tx/rx shifters and outputs.

Test Plan:
1. Defaults, wdata=16'hA5C3, MISO driven by a mode-0 slave model returning 16'h3C5A:
   - MOSI bits on leading edges read A5C3;
   - rdata=16'h3C5A at done;
   - done at T+545;
   - exactly 16 SCLK rising edges while SS_n=0.
2. Mode sweep CPOL/CPHA = 00, 01, 10, 11 with DATA_W=8, DIV_LOG2=3, wdata=8'h96, loopback MOSI->MISO:
   - rdata=8'h96 in every mode;
   - SCLK idle level equals CPOL before and after the frame.
3. wrt re-asserted mid-frame, plus wrt coincident with done:
   - the mid-frame wrt changes nothing and the first rdata is intact;
   - the coincident wrt starts a second frame with a one-cycle SS_n high gap and a second done after another 545 cycles.
4. rst_n pulsed low at cycle 200 of a frame:
   - immediately SS_n=1, SCLK=CPOL, busy=0, MOSI=0;
   - no done pulse;
   - the next wrt gives a clean full frame.
5. DATA_W=32, DIV_LOG2=2, wdata=32'hDEADBEEF, loopback:
   - rdata=32'hDEADBEEF;
   - done at T+1+2*66=T+133.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the full-duplex SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    // Edge counter must reach 2*data_w, the count after the last trailing edge
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mstr_fd_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_fd_if
// Description : Host handshake and SPI pin bundle for spi_mstr_fd.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_mstr_fd_if #(
    parameter int DATA_W = 16
);
    logic              wrt;
    logic [DATA_W-1:0] wdata;
    logic              MISO;
    logic              SS_n;
    logic              SCLK;
    logic              MOSI;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  wrt, wdata, MISO,
        output SS_n, SCLK, MOSI, busy, done, rdata
    );

    modport slave (
        output wrt, wdata, MISO,
        input  SS_n, SCLK, MOSI, busy, done, rdata
    );
endinterface
`default_nettype wire

// File: rtl/spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_sclk_gen
// Description : Half-period divider, registered SCLK and edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sclk_gen #(
    parameter int DIV_LOG2 = 5,
    parameter bit CPOL     = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_run,
    input  wire logic i_toggle_en,
    output logic      o_sclk,
    output logic      o_half_tick,
    output logic      o_lead_edge,
    output logic      o_trail_edge
);

    localparam int c_div_w = DIV_LOG2 - 1;

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_sclk;
    logic               w_tick;
    logic               w_toggle;

    // Counter wraps naturally at H, so all-ones marks the last cycle of a half-period
    assign w_tick   = i_run && (r_div_cnt == '1);
    assign w_toggle = w_tick && i_toggle_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_sclk    <= CPOL;
        end else if (!i_run) begin
            r_div_cnt <= '0;
            r_sclk    <= CPOL;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            if (w_toggle) begin
                r_sclk <= ~r_sclk;
            end
        end
    end

    assign o_sclk       = r_sclk;
    assign o_half_tick  = w_tick;
    assign o_lead_edge  = w_toggle && (r_sclk == CPOL);
    assign o_trail_edge = w_toggle && (r_sclk != CPOL);

endmodule
`default_nettype wire

// File: rtl/spi_mstr_fd.sv
`default_nettype none
// ============================================================================
// Module      : spi_mstr_fd
// Description : Parametrised full-duplex SPI master, one word per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mstr_fd
    import spi_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DIV_LOG2 = 5,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    spi_mstr_fd_if.master bus
);

    localparam int                  c_ecnt_w    = edge_cnt_w(DATA_W);
    localparam logic [c_ecnt_w-1:0] c_last_edge = c_ecnt_w'(2 * DATA_W - 1);

    spi_state_t          r_state;
    spi_state_t          w_state_nxt;
    logic [DATA_W-1:0]   r_tx_sh;
    logic [DATA_W-1:0]   r_rx_sh;
    logic [DATA_W-1:0]   r_rdata;
    logic [c_ecnt_w-1:0] r_edge_cnt;
    logic                r_ss_n;
    logic                r_busy;
    logic                r_done;
    logic                w_start;
    logic                w_finish;
    logic                w_tick;
    logic                w_lead;
    logic                w_trail;
    logic                w_sclk;
    logic                w_shift_tx;
    logic                w_sample_rx;

    spi_sclk_gen #(
        .DIV_LOG2 (DIV_LOG2),
        .CPOL     (CPOL)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (r_state != IDLE),
        .i_toggle_en  (r_state == XFER),
        .o_sclk       (w_sclk),
        .o_half_tick  (w_tick),
        .o_lead_edge  (w_lead),
        .o_trail_edge (w_trail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.wrt) begin
                    w_state_nxt = SETUP;
                    w_start     = 1'b1;
                end
            end
            SETUP: begin
                if (w_tick) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_tick && (r_edge_cnt == c_last_edge)) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // CPHA=1 presents the MSB at SS_n fall, so the first leading edge must not shift
    generate
        if (CPHA == 1'b0) begin : g_cpha0
            assign w_sample_rx = w_lead;
            assign w_shift_tx  = w_trail;
        end else begin : g_cpha1
            assign w_sample_rx = w_trail;
            assign w_shift_tx  = w_lead && (r_edge_cnt != '0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_rdata    <= '0;
            r_edge_cnt <= '0;
            r_ss_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_start) begin
                r_tx_sh    <= bus.wdata;
                r_rx_sh    <= '0;
                r_edge_cnt <= '0;
                r_ss_n     <= 1'b0;
                r_busy     <= 1'b1;
            end else begin
                if (w_shift_tx) begin
                    r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                end
                if (w_sample_rx) begin
                    r_rx_sh <= {r_rx_sh[DATA_W-2:0], bus.MISO};
                end
                if (w_lead || w_trail) begin
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
                if (w_finish) begin
                    r_ss_n  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_rdata <= r_rx_sh;
                end
            end
        end
    end

    assign bus.SS_n  = r_ss_n;
    assign bus.SCLK  = w_sclk;
    assign bus.MOSI  = !r_ss_n && r_tx_sh[DATA_W-1];
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire
